// File: rtl/nr_div_pkg.sv
// nr_div_pkg: shared FSM state encoding and default operand width for nr_divider.
package nr_div_pkg;

    localparam int DEF_WIDTH = 32;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t FIX  = 2'd2;
    localparam state_t DONE = 2'd3;

endpackage

// File: rtl/nr_addsub.sv
// nr_addsub: WIDTH+1-bit adder/subtractor shared by the iteration and fix-up steps.
module nr_addsub #(
    parameter int W = 32
) (
    input  logic [W:0] a,
    input  logic [W:0] b,
    input  logic       sub,
    output logic [W:0] y
);

    assign y = sub ? a - b : a + b;

endmodule

// File: rtl/nr_divider.sv
// nr_divider: multi-cycle non-restoring divider (WIDTH+2 cycle latency).
// Define NR_DIVIDER_SIGNED_EN to add the signed_op port for two's complement operands.
module nr_divider
    import nr_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef NR_DIVIDER_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   pr, as_a, as_y;
    logic [WIDTH-1:0] q, d;
    logic [WIDTH-1:0] a_mag, b_mag, r_fix, q_fin, r_fin;
    logic             as_sub, accept;

    assign ready  = (state == IDLE) || (state == DONE);
    assign done   = state == DONE;
    assign accept = start && ready;

    // RUN shifts the next dividend bit into the partial remainder; FIX only restores a negative one
    assign as_a   = (state == FIX) ? pr : {pr[WIDTH-1:0], q[WIDTH-1]};
    assign as_sub = (state != FIX) && !pr[WIDTH];
    assign r_fix  = pr[WIDTH] ? as_y[WIDTH-1:0] : pr[WIDTH-1:0];

    nr_addsub #(.W(WIDTH)) u_addsub (
        .a   (as_a),
        .b   ({1'b0, d}),
        .sub (as_sub),
        .y   (as_y)
    );

`ifdef NR_DIVIDER_SIGNED_EN
    logic sa, sb, neg_q, neg_r;
    assign sa    = signed_op && dividend[WIDTH-1];
    assign sb    = signed_op && divisor[WIDTH-1];
    assign a_mag = sa ? -dividend : dividend;
    assign b_mag = sb ? -divisor : divisor;
    assign q_fin = neg_q ? -q : q;
    assign r_fin = neg_r ? -r_fix : r_fix;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= sa ^ sb;
            neg_r <= sa;
        end
    end
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign q_fin = q;
    assign r_fin = r_fix;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            pr          <= '0;
            q           <= '0;
            d           <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (divisor == '0) begin
                state       <= DONE;
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                state <= RUN;
                cnt   <= '0;
                pr    <= '0;
                q     <= a_mag;
                d     <= b_mag;
            end
        end else if (state == RUN) begin
            pr  <= as_y;
            q   <= {q[WIDTH-2:0], ~as_y[WIDTH]};
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1))
                state <= FIX;
        end else if (state == FIX) begin
            state       <= DONE;
            quotient    <= q_fin;
            remainder   <= r_fin;
            div_by_zero <= 1'b0;
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end

endmodule
